// File: rtl/spm_port_arb.sv
// Port B arbiter for the scratch-pad memory: single-word MEM accesses versus
// auto-incrementing DMA bursts, with a starvation guard so DMA always progresses.
module spm_port_arb #(
    parameter  int ADDR_W       = 12,
    parameter  int DATA_W       = 32,
    parameter  int BURST_MAX    = 16,
    parameter  int STARVE_LIMIT = 8,
    localparam int LEN_W        = $clog2(BURST_MAX + 1)
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_as_,
    input  logic              mem_rw,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_stall,
    input  logic              dma_req,
    input  logic              dma_rw,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [LEN_W-1:0]  dma_len,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_wr_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic              dma_done,
    output logic [ADDR_W-1:0] spm_addr,
    output logic              spm_as_,
    output logic              spm_rw,
    output logic [DATA_W-1:0] spm_wdata,
    input  logic [DATA_W-1:0] spm_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        ST_IDLE,
        ST_DMA_BURST
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_MEM,
        OWN_DMA
    } owner_t;

    state_t            state_q, state_d;
    owner_t            rdOwner_q, rdOwner_d;
    logic [SW-1:0]     starveCnt_q, starveCnt_d;
    logic [ADDR_W-1:0] burstAddr_q, burstAddr_d;
    logic              burstRw_q, burstRw_d;
    logic [LEN_W-1:0]  beatCnt_q, beatCnt_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] memHold_q, memHold_d;

    logic [LEN_W-1:0]  lenEff;
    logic              dmaWin;
    logic              memWin;

    // A zero length still moves one word; oversize requests are cut to BURST_MAX.
    always_comb begin
        lenEff = dma_len;
        if (dma_len == '0) begin
            lenEff = LEN_W'(1);
        end else if (dma_len > LEN_W'(BURST_MAX)) begin
            lenEff = LEN_W'(BURST_MAX);
        end
    end

    always_comb begin
        state_d     = state_q;
        rdOwner_d   = OWN_NONE;
        starveCnt_d = starveCnt_q;
        burstAddr_d = burstAddr_q;
        burstRw_d   = burstRw_q;
        beatCnt_d   = beatCnt_q;
        done_d      = 1'b0;
        memHold_d   = (rdOwner_q == OWN_MEM) ? spm_rdata : memHold_q;

        dmaWin      = 1'b0;
        memWin      = 1'b0;
        spm_as_     = 1'b1;
        spm_addr    = mem_addr;
        spm_rw      = 1'b1;
        spm_wdata   = mem_wdata;
        mem_stall   = 1'b0;
        dma_gnt     = 1'b0;
        dma_wr_ack  = 1'b0;

        if (!reset_) begin
            case (state_q)
                ST_IDLE: begin
                    dmaWin = dma_req && (mem_as_ || (starveCnt_q == SW'(STARVE_LIMIT)));
                    memWin = !dmaWin && !mem_as_;
                    if (dmaWin) begin
                        dma_gnt     = 1'b1;
                        mem_stall   = !mem_as_;
                        burstAddr_d = dma_addr;
                        burstRw_d   = dma_rw;
                        beatCnt_d   = lenEff;
                        starveCnt_d = '0;
                        state_d     = ST_DMA_BURST;
                    end else if (memWin) begin
                        spm_as_   = 1'b0;
                        spm_addr  = mem_addr;
                        spm_rw    = mem_rw;
                        spm_wdata = mem_wdata;
                        if (mem_rw) begin
                            rdOwner_d = OWN_MEM;
                        end
                        if (dma_req && (starveCnt_q != SW'(STARVE_LIMIT))) begin
                            starveCnt_d = starveCnt_q + SW'(1);
                        end
                    end
                    if (!dma_req) begin
                        starveCnt_d = '0;
                    end
                end
                ST_DMA_BURST: begin
                    spm_as_     = 1'b0;
                    spm_addr    = burstAddr_q;
                    spm_rw      = burstRw_q;
                    spm_wdata   = dma_wdata;
                    dma_wr_ack  = !burstRw_q;
                    mem_stall   = !mem_as_;
                    rdOwner_d   = burstRw_q ? OWN_DMA : OWN_NONE;
                    burstAddr_d = burstAddr_q + ADDR_W'(1);
                    beatCnt_d   = beatCnt_q - LEN_W'(1);
                    if (beatCnt_q == LEN_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Read data lands one cycle after the access; done for a read burst lines up
    // with the final rvalid because both come from the last beat one cycle late.
    assign dma_rdata  = spm_rdata;
    assign dma_rvalid = !reset_ && (rdOwner_q == OWN_DMA);
    assign dma_done   = !reset_ && done_q;
    assign mem_rdata  = (rdOwner_q == OWN_MEM) ? spm_rdata : memHold_q;

    always_ff @(posedge clk) begin
        if (reset_) begin
            state_q     <= ST_IDLE;
            rdOwner_q   <= OWN_NONE;
            starveCnt_q <= '0;
            burstAddr_q <= '0;
            burstRw_q   <= 1'b0;
            beatCnt_q   <= '0;
            done_q      <= 1'b0;
            memHold_q   <= '0;
        end else begin
            state_q     <= state_d;
            rdOwner_q   <= rdOwner_d;
            starveCnt_q <= starveCnt_d;
            burstAddr_q <= burstAddr_d;
            burstRw_q   <= burstRw_d;
            beatCnt_q   <= beatCnt_d;
            done_q      <= done_d;
            memHold_q   <= memHold_d;
        end
    end

endmodule

// File: tb/tb_spm_port_arb.sv
// Bench for spm_port_arb: directed scenarios plus random traffic, all checked against
// a transaction-level model of the arbitration rules and a reference memory image.
module tb_spm_port_arb;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int BM = 16;
    localparam int SL = 8;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          reset_;
    logic [AW-1:0] mem_addr;
    logic          mem_as_;
    logic          mem_rw;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_stall;
    logic          dma_req;
    logic          dma_rw;
    logic [AW-1:0] dma_addr;
    logic [LW-1:0] dma_len;
    logic [DW-1:0] dma_wdata;
    logic          dma_gnt;
    logic          dma_wr_ack;
    logic [DW-1:0] dma_rdata;
    logic          dma_rvalid;
    logic          dma_done;
    logic [AW-1:0] spm_addr;
    logic          spm_as_;
    logic          spm_rw;
    logic [DW-1:0] spm_wdata;
    logic [DW-1:0] spm_rdata;

    always #5 clk = ~clk;

    spm_port_arb #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BM), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .reset_(reset_),
        .mem_addr(mem_addr), .mem_as_(mem_as_), .mem_rw(mem_rw), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_stall(mem_stall),
        .dma_req(dma_req), .dma_rw(dma_rw), .dma_addr(dma_addr), .dma_len(dma_len),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_wr_ack(dma_wr_ack),
        .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid), .dma_done(dma_done),
        .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw), .spm_wdata(spm_wdata),
        .spm_rdata(spm_rdata)
    );

    // Preloaded contents of never-written SPM words; 0x010 holds the known pattern.
    function automatic logic [31:0] initWord(input int a);
        return (a == 16) ? 32'hDEADBEEF : ({12'hC0F, 20'(a)} ^ 32'h1357_9BDF);
    endfunction

    logic [31:0] ram [0:4095];
    bit          written [0:4095];

    always @(posedge clk) begin
        if (!spm_as_) begin
            if (spm_rw) begin
                spm_rdata <= written[spm_addr] ? ram[spm_addr] : initWord(int'(spm_addr));
            end else begin
                ram[spm_addr]     <= spm_wdata;
                written[spm_addr] <= 1'b1;
            end
        end
    end

    // Reference model state
    logic [31:0] refMem [0:4095];
    bit          mBusy;
    int          mLeft;
    int          mAddr;
    bit          mRead;
    int          mStarve;
    int          mRet;
    logic [31:0] mRetData;
    logic [31:0] mHold;
    bit          mDone;
    bit          expGnt, expStall;

    bit          obsGnt, obsStall, obsAck, obsBeat, obsRvalid, obsDone;
    logic [31:0] obsMemRdata;

    int compareCount = 0;
    int mismatchCount = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Compare one cycle of DUT behaviour with the model, then advance the model.
    task automatic stepCycle();
        bit          dWin, mWin;
        int          nRet, len;
        logic [31:0] nData;
        bit          nDone, expAck;
        @(negedge clk);
        obsGnt      = dma_gnt;
        obsStall    = mem_stall;
        obsAck      = dma_wr_ack;
        obsBeat     = !spm_as_;
        obsRvalid   = dma_rvalid;
        obsDone     = dma_done;
        obsMemRdata = mem_rdata;
        if (reset_) begin
            checkOutput("rst_spm_as", 32'(spm_as_), 32'd1);
            checkOutput("rst_gnt", 32'(dma_gnt), 32'd0);
            checkOutput("rst_wr_ack", 32'(dma_wr_ack), 32'd0);
            checkOutput("rst_rvalid", 32'(dma_rvalid), 32'd0);
            checkOutput("rst_done", 32'(dma_done), 32'd0);
            checkOutput("rst_stall", 32'(mem_stall), 32'd0);
            mBusy = 0; mStarve = 0; mRet = 0; mDone = 0; mHold = '0;
            expGnt = 0; expStall = 0;
        end else begin
            nRet = 0; nData = '0; nDone = 0; expAck = 0;
            checkOutput("dma_rvalid", 32'(dma_rvalid), 32'(mRet == 2));
            if (mRet == 2) checkOutput("dma_rdata", dma_rdata, mRetData);
            checkOutput("mem_rdata", mem_rdata, (mRet == 1) ? mRetData : mHold);
            checkOutput("dma_done", 32'(dma_done), 32'(mDone));
            if (mRet == 1) mHold = mRetData;
            if (!mBusy) begin
                dWin = dma_req && (mem_as_ || mStarve == SL);
                mWin = !dWin && !mem_as_;
                expGnt = dWin;
                expStall = !mem_as_ && !mWin;
                checkOutput("spm_as_", 32'(spm_as_), 32'(!mWin));
                if (mWin) begin
                    checkOutput("mem_spm_addr", 32'(spm_addr), 32'(mem_addr));
                    checkOutput("mem_spm_rw", 32'(spm_rw), 32'(mem_rw));
                    if (mem_rw) begin
                        nRet = 1;
                        nData = refMem[mem_addr];
                    end else begin
                        checkOutput("mem_spm_wdata", spm_wdata, mem_wdata);
                        refMem[mem_addr] = mem_wdata;
                    end
                end
                if (dWin || !dma_req) mStarve = 0;
                else if (mWin && mStarve < SL) mStarve++;
                if (dWin) begin
                    len = int'(dma_len);
                    mLeft = (len == 0) ? 1 : ((len > BM) ? BM : len);
                    mAddr = int'(dma_addr);
                    mRead = dma_rw;
                    mBusy = 1;
                end
            end else begin
                expGnt = 0;
                expStall = !mem_as_;
                expAck = !mRead;
                checkOutput("beat_spm_as", 32'(spm_as_), 32'd0);
                checkOutput("beat_spm_addr", 32'(spm_addr), 32'(mAddr));
                checkOutput("beat_spm_rw", 32'(spm_rw), 32'(mRead));
                if (mRead) begin
                    nRet = 2;
                    nData = refMem[mAddr];
                end else begin
                    checkOutput("beat_spm_wdata", spm_wdata, dma_wdata);
                    refMem[mAddr] = dma_wdata;
                end
                mAddr = (mAddr + 1) % 4096;
                mLeft--;
                if (mLeft == 0) begin
                    mBusy = 0;
                    nDone = 1;
                end
            end
            checkOutput("dma_gnt", 32'(dma_gnt), 32'(expGnt));
            checkOutput("mem_stall", 32'(mem_stall), 32'(expStall));
            checkOutput("dma_wr_ack", 32'(dma_wr_ack), 32'(expAck));
            mRet = nRet;
            mRetData = nData;
            mDone = nDone;
        end
        @(posedge clk);
        #1;
    endtask

    // Run one DMA burst. memMode: 0 = MEM idle, 1 = MEM strobes every cycle,
    // 2 = MEM idle until the grant, then reads.
    task automatic runDma(input bit rw, input int addr, input int len, input int memMode,
                          output int preGrants, output int stallRun, output int beats,
                          output int rvalids, output int gntAt, output int doneAt);
        bit granted = 0, doneSeen = 0, stallActive = 0;
        int ackCount = 0;
        preGrants = 0; stallRun = 0; beats = 0; rvalids = 0; gntAt = -1; doneAt = -1;
        dma_req = 1; dma_rw = rw; dma_addr = 12'(addr); dma_len = 5'(len);
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (!expStall) begin
                mem_addr  = 12'($urandom);
                mem_wdata = $urandom;
                mem_rw    = (memMode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            mem_as_ = (memMode == 1 || (memMode == 2 && granted)) ? 1'b0 : 1'b1;
            dma_wdata = 32'hDA7A_0000 + 32'(ackCount);
            stepCycle();
            if (obsAck) ackCount++;
            if (obsRvalid) rvalids++;
            if (!granted && !mem_as_ && !obsStall) preGrants++;
            if (granted && !doneSeen && !obsDone && obsBeat) beats++;
            if (obsGnt && !granted) begin
                granted = 1; gntAt = cyc; dma_req = 0; stallActive = 1;
            end
            if (stallActive) begin
                if (obsStall) stallRun++;
                else stallActive = 0;
            end
            if (obsDone && !doneSeen) begin
                doneSeen = 1; doneAt = cyc;
            end
            if (doneSeen && cyc >= doneAt + 2) break;
        end
        checkOutput("dma_complete", 32'(doneSeen), 32'd1);
        dma_req = 0;
        mem_as_ = 1;
    endtask

    int pg, sr, bt, rv, ga, da;
    int abortBeats, abortDone, abortRvalid;
    bit reqActive;

    initial begin
        for (int i = 0; i < 4096; i++) refMem[i] = initWord(i);
        reset_ = 1; mem_as_ = 0; mem_rw = 1; mem_addr = 12'h010; mem_wdata = '0;
        dma_req = 0; dma_rw = 0; dma_addr = '0; dma_len = '0; dma_wdata = '0;
        mBusy = 0; mStarve = 0; mRet = 0; mDone = 0; mHold = '0; expGnt = 0; expStall = 0;

        // Reset held with a MEM strobe pending
        stepCycle();
        stepCycle();
        reset_ = 0;

        // Single MEM read of the preloaded word
        stepCycle();
        checkOutput("t2_stall", 32'(obsStall), 32'd0);
        mem_as_ = 1;
        stepCycle();
        checkOutput("t2_mem_rdata", obsMemRdata, 32'hDEADBEEF);

        // Write burst wrapping across the top of the address space
        runDma(0, 12'hFFE, 4, 0, pg, sr, bt, rv, ga, da);
        checkOutput("t3_beats", 32'(bt), 32'd4);
        checkOutput("t3_done_lat", 32'(da - ga), 32'd5);
        checkOutput("t3_ram_ffe", ram[12'hFFE], 32'hDA7A_0000);
        checkOutput("t3_ram_fff", ram[12'hFFF], 32'hDA7A_0001);
        checkOutput("t3_ram_000", ram[12'h000], 32'hDA7A_0002);
        checkOutput("t3_ram_001", ram[12'h001], 32'hDA7A_0003);

        // MEM hammering the port: DMA must win after the starvation limit
        runDma(0, 12'h100, 3, 1, pg, sr, bt, rv, ga, da);
        checkOutput("t4_mem_grants", 32'(pg), 32'd8);
        checkOutput("t4_stall_run", 32'(sr), 32'd4);

        // DMA read burst immediately followed by a MEM read
        runDma(1, 12'h020, 2, 2, pg, sr, bt, rv, ga, da);
        checkOutput("t5_rvalids", 32'(rv), 32'd2);

        // Reset in the middle of a long read burst
        dma_req = 1; dma_rw = 1; dma_addr = 12'h200; dma_len = 5'd8; mem_as_ = 1;
        stepCycle();
        checkOutput("t6_gnt", 32'(obsGnt), 32'd1);
        dma_req = 0;
        stepCycle();
        reset_ = 1;
        stepCycle();
        reset_ = 0;
        abortBeats = 0; abortDone = 0; abortRvalid = 0;
        for (int i = 0; i < 12; i++) begin
            stepCycle();
            if (obsBeat) abortBeats++;
            if (obsDone) abortDone++;
            if (obsRvalid) abortRvalid++;
        end
        checkOutput("t6_beats", 32'(abortBeats), 32'd0);
        checkOutput("t6_done", 32'(abortDone), 32'd0);
        checkOutput("t6_rvalid", 32'(abortRvalid), 32'd0);
        runDma(0, 12'h300, 1, 1, pg, sr, bt, rv, ga, da);
        checkOutput("t6_starve_clear", 32'(pg), 32'd8);

        // Length edge cases
        runDma(0, 12'h400, 0, 0, pg, sr, bt, rv, ga, da);
        checkOutput("t7_len0_beats", 32'(bt), 32'd1);
        runDma(1, 12'h500, 31, 0, pg, sr, bt, rv, ga, da);
        checkOutput("t7_len31_beats", 32'(bt), 32'd16);
        checkOutput("t7_len31_rvalids", 32'(rv), 32'd16);

        // Random mixed traffic
        reqActive = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!expStall) begin
                mem_as_   = 1'($urandom_range(0, 1));
                mem_rw    = 1'($urandom_range(0, 1));
                mem_addr  = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(4090, 4095)) : 12'($urandom);
                mem_wdata = $urandom;
            end
            if (!reqActive && $urandom_range(0, 7) == 0) begin
                reqActive = 1;
                dma_rw   = 1'($urandom_range(0, 1));
                dma_addr = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(4085, 4095)) : 12'($urandom);
                dma_len  = 5'($urandom_range(0, 31));
            end else if (reqActive && $urandom_range(0, 31) == 0) begin
                reqActive = 0;
            end
            dma_req   = reqActive;
            dma_wdata = $urandom;
            reset_    = ($urandom_range(0, 499) == 0);
            stepCycle();
            if (expGnt) reqActive = 0;
        end
        reset_ = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
